// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between the EX-stage driver and alu_exec_unit.
// Overflow is present only when ALU_OVERFLOW_EN is defined.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       Shamt;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             busy;
  logic             done;
`ifdef ALU_OVERFLOW_EN
  logic             Overflow;

  modport master (output start, ALUControl, A, B, Shamt,
                  input  Result, Zero, busy, done, Overflow);
  modport slave  (input  start, ALUControl, A, B, Shamt,
                  output Result, Zero, busy, done, Overflow);
`else
  modport master (output start, ALUControl, A, B, Shamt,
                  input  Result, Zero, busy, done);
  modport slave  (input  start, ALUControl, A, B, Shamt,
                  output Result, Zero, busy, done);
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// Registered EX-stage ALU: single-cycle ops finish in one clock, SLL shifts one bit per cycle.
// Optional Overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [4:0]       cnt, cnt_next;
  logic [WIDTH-1:0] result, result_next;
  logic             zero, zero_next;
  logic             done, done_next;
  logic [WIDTH-1:0] sum, diff, op_result;
  logic             is_shift;

  assign sum      = bus.A + bus.B;
  assign diff     = bus.A - bus.B;
  assign is_shift = (bus.ALUControl == OP_SLL) && (bus.Shamt != 5'd0);

  // NOP (JR) and undefined codes fall through to a zero result.
  always_comb begin
    op_result = '0;
    case (bus.ALUControl)
      OP_ADD:  op_result = sum;
      OP_SUB:  op_result = diff;
      OP_AND:  op_result = bus.A & bus.B;
      OP_NOR:  op_result = ~(bus.A | bus.B);
      OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL:  op_result = bus.B;
      default: op_result = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf, ovf_next, op_ovf;

  always_comb begin
    op_ovf = 1'b0;
    case (bus.ALUControl)
      OP_ADD:  op_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      OP_SUB:  op_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      default: op_ovf = 1'b0;
    endcase
  end

  assign bus.Overflow = ovf;
`endif

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    cnt_next    = cnt;
    result_next = result;
    zero_next   = zero;
    done_next   = 1'b0;
`ifdef ALU_OVERFLOW_EN
    ovf_next    = ovf;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_shift) begin
            acc_next   = bus.B;
            cnt_next   = bus.Shamt;
            state_next = SHIFT;
          end else begin
            result_next = op_result;
            zero_next   = (op_result == '0);
            done_next   = 1'b1;
`ifdef ALU_OVERFLOW_EN
            ovf_next    = op_ovf;
`endif
          end
        end
      end
      SHIFT: begin
        acc_next = acc << 1;
        cnt_next = cnt - 5'd1;
        // Last step: publish the final shift directly rather than waiting a cycle for acc.
        if (cnt == 5'd1) begin
          result_next = acc << 1;
          zero_next   = ((acc << 1) == '0);
          done_next   = 1'b1;
          state_next  = IDLE;
`ifdef ALU_OVERFLOW_EN
          ovf_next    = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
      done   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      result <= result_next;
      zero   <= zero_next;
      done   <= done_next;
`ifdef ALU_OVERFLOW_EN
      ovf    <= ovf_next;
`endif
    end
  end

  assign bus.Result = result;
  assign bus.Zero   = zero;
  assign bus.done   = done;
  assign bus.busy   = (state == SHIFT);

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. It sits in the EX stage between the decoder and the EX/MEM result register. A start/done handshake lets single-cycle ops finish in one clock, while SLL runs as an iterative one-bit-per-cycle shifter.

## Interface
Parameters:
- WIDTH, 32, operand/result width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- ALUControl  input  4  op code: 0010 ADD, 0110 SUB, 0000 AND, 1100 NOR, 0111 SLT, 1110 SLL, 1111 NOP (JR).
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt/immediate); SLL source.
- Shamt  input  5  SLL shift amount.
- Result  output  WIDTH  registered result; holds until next done.
- Zero  output  1  registered, 1 when the Result written at done is all zeros.
- busy  output  1  high while SLL iteration is in progress.
- done  output  1  one-cycle pulse; Result/Zero valid in that cycle.
- Overflow  output  1  only when ALU_OVERFLOW_EN is defined (see Configuration).

## Operation
- States: IDLE, SHIFT. Reset → IDLE.
- IDLE, start=1, op ≠ SLL (or SLL with Shamt=0): compute combinationally, register Result/Zero, done←1, stay IDLE.
  - ADD: A+B mod 2^WIDTH. SUB: A−B mod 2^WIDTH. AND: A&B. NOR: ~(A|B).
  - SLT: signed compare; Result = {0…0, (A<B)}.
  - SLL with Shamt=0: Result=B.
  - NOP 1111 and any undefined code: Result=0, Zero=1, done still pulses.
- IDLE, start=1, SLL, Shamt=k≥1: acc←B, cnt←k, state←SHIFT, busy←1, no done.
- SHIFT, each edge: acc←acc<<1, cnt←cnt−1. When cnt==1: Result←acc<<1, Zero updated, done←1, busy←0, state←IDLE.
- start while busy=1: ignored, no queueing. Operand/code changes during SHIFT have no effect (latched at acceptance).
- done is low in every cycle not listed above. Result/Zero are not modified except when done is asserted.

## Timing
- Reset values: Result=0, Zero=0, busy=0, done=0, Overflow=0, state=IDLE, acc=0, cnt=0.
- Reset asserted mid-SHIFT: next edge returns to IDLE with all outputs at reset values; the in-flight op is dropped with no done.
- Reset has priority over start.
- Single-cycle op accepted at the edge ending cycle N: done high in cycle N+1. Latency 1.
- SLL with k≥1 accepted at the edge ending cycle N: busy high in cycles N+1..N+k, done high in cycle N+k+1. Latency k+1.
- Back-to-back: in IDLE, start in the same cycle as done is accepted; a single-cycle op stream gives done every cycle.
- Shamt=31: 32-cycle latency, Result = B[0]<<31.

## Configuration
- ALU_OVERFLOW_EN defined: adds the Overflow port.
  - Registered at done: 1 for ADD when A and B have the same sign and the sum's sign differs; 1 for SUB when A and B signs differ and the result's sign differs from A.
  - 0 for all other ops.
  - Result is still the wrapped value; no trap.
- Undefined: the Overflow port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then ADD, A=0x7FFFFFFF, B=1 → next cycle done=1, Result=0x80000000, Zero=0. With ALU_OVERFLOW_EN: Overflow=1.
- SUB, A=5, B=5 → Result=0, Zero=1. SLT, A=0xFFFFFFFF, B=1 → Result=1. NOR, A=0, B=0 → Result=0xFFFFFFFF.
- SLL, B=0x00000003, Shamt=4 → busy high 4 cycles, done in the 5th cycle, Result=0x30. A start pulse during busy is ignored (no extra done).
- Back-to-back: AND, A=0xF0F0F0F0, B=0xFF00FF00, then ADD, A=1, B=2 on consecutive cycles → done two consecutive cycles, Results 0xF000F000 then 3.
- SLL, Shamt=10, then reset asserted in the 3rd busy cycle → next cycle busy=0, Result=0, done never pulses.
- Code 1111 (JR) and undefined code 0101 → done=1, Result=0, Zero=1.
